// File: rtl/asip_pkg.sv
// Shared types and constants for the control-flow redirect path.
package asip_pkg;

    typedef enum logic [1:0] {
        BR_COND_REL   = 2'b00,
        BR_UNCOND_REL = 2'b01,
        BR_JUMP_ABS   = 2'b10,
        BR_RESERVED   = 2'b11
    } br_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_HOLD     = 2'b10,
        ST_FLUSH    = 2'b11
    } redirect_state_t;

    // Instruction size in bytes; targets must be multiples of this.
    localparam int PC_STEP    = 4;
    localparam int ALIGN_BITS = $clog2(PC_STEP);

endpackage

// File: rtl/branch_target_calc.sv
// Combinational resolution of a control-flow instruction: taken decision,
// word-aligned target and a flag for a raw target that was not aligned.
module branch_target_calc
    import asip_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [1:0]      brType,
    input  logic            brCond,
    input  logic [PC_W-1:0] brPc,
    input  logic [PC_W-1:0] brOffset,
    input  logic [PC_W-1:0] brTarget,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic            misaligned
);

    br_type_t        br_type;
    logic [PC_W-1:0] raw_target;

    assign br_type = br_type_t'(brType);

    // Taken decision and raw target; the relative add wraps modulo 2^PC_W,
    // and with equal widths the signed offset needs no explicit extension.
    always_comb begin
        taken      = 1'b0;
        raw_target = brPc + brOffset;
        case (br_type)
            BR_COND_REL:   taken = brCond;
            BR_UNCOND_REL: taken = 1'b1;
            BR_JUMP_ABS: begin
                taken      = 1'b1;
                raw_target = brTarget;
            end
            default:       taken = 1'b0;
        endcase
    end

    assign target     = {raw_target[PC_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign misaligned = |raw_target[ALIGN_BITS-1:0];

endmodule

// File: rtl/pc_redirect_unit.sv
// Redirect controller between execute and fetch.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for a resolved branch; not-taken COND_REL counted here
//   REDIRECT | pcWrEn pulse, newPc valid, both flushes high, takenCnt++
//   HOLD     | newPc held for fetch's delayed enable, flushes still high
//   FLUSH    | extra flush cycles beyond the first two (FLUSH_CYCLES > 2)
//
// busy covers every non-IDLE state, so a branch arriving in the cycle the FSM
// returns to IDLE is still on the wrong path and is dropped.
// FLUSH_CYCLES must be at least 2.
module pc_redirect_unit
    import asip_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             brValid,
    input  logic [1:0]       brType,
    input  logic             brCond,
    input  logic [PC_W-1:0]  brPc,
    input  logic [PC_W-1:0]  brOffset,
    input  logic [PC_W-1:0]  brTarget,
    output logic             pcWrEn,
    output logic [PC_W-1:0]  newPc,
    output logic             flushIfId,
    output logic             flushIdEx,
    output logic             busy,
    output logic             misalign,
    output logic [CNT_W-1:0] takenCnt,
    output logic [CNT_W-1:0] notTknCnt
);

    // Flush cycles left after HOLD; REDIRECT and HOLD account for two.
    localparam int                FC_W        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]   FLUSH_EXTRA = FC_W'(FLUSH_CYCLES - 2);

    redirect_state_t state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [PC_W-1:0] target_q;
    logic            misalign_q;
    logic [CNT_W-1:0] taken_cnt_q, not_tkn_cnt_q;

    logic            calc_taken;
    logic [PC_W-1:0] calc_target;
    logic            calc_misaligned;
    logic            is_cond_rel;

    logic            load_target;
    logic            set_misalign;
    logic            inc_taken;
    logic            inc_not_tkn;

    branch_target_calc #(
        .PC_W (PC_W)
    ) u_target_calc (
        .brType     (brType),
        .brCond     (brCond),
        .brPc       (brPc),
        .brOffset   (brOffset),
        .brTarget   (brTarget),
        .taken      (calc_taken),
        .target     (calc_target),
        .misaligned (calc_misaligned)
    );

    assign is_cond_rel = (br_type_t'(brType) == BR_COND_REL);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the datapath update strobes.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        load_target  = 1'b0;
        set_misalign = 1'b0;
        inc_taken    = 1'b0;
        inc_not_tkn  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (brValid) begin
                    if (calc_taken) begin
                        load_target  = 1'b1;
                        set_misalign = calc_misaligned;
                        state_d      = ST_REDIRECT;
                    end else if (is_cond_rel) begin
                        inc_not_tkn = 1'b1;
                    end
                end
            end
            ST_REDIRECT: begin
                inc_taken   = 1'b1;
                flush_cnt_d = FLUSH_EXTRA;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = (flush_cnt_q == '0) ? ST_IDLE : ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FC_W'(1);
                if (flush_cnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Target register, flush down-counter and sticky misalign flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q    <= '0;
            flush_cnt_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            if (load_target) begin
                target_q <= calc_target;
            end
            if (set_misalign) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q   <= '0;
            not_tkn_cnt_q <= '0;
        end else begin
            if (inc_taken && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
            if (inc_not_tkn && (not_tkn_cnt_q != '1)) begin
                not_tkn_cnt_q <= not_tkn_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pcWrEn    = (state_q == ST_REDIRECT);
    assign busy      = (state_q != ST_IDLE);
    assign flushIfId = busy;
    assign flushIdEx = busy;
    assign newPc     = target_q;
    assign misalign  = misalign_q;
    assign takenCnt  = taken_cnt_q;
    assign notTknCnt = not_tkn_cnt_q;

endmodule
